// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame width, line idle level, rx state encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    RX_WAIT_IDLE,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rd_dat whenever not empty.
// Latency: a write is visible on rd_dat the cycle after the push edge; pop advances the head next cycle.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = rd_rdy & ~empty;
  assign do_push = wr_vld & (~full | do_pop);
  assign count   = count_q;
  // Head is forced to zero when empty so a freshly reset FIFO presents 0x00.
  assign rd_dat  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge core_clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers and occupancy; pointers wrap naturally at their width.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered 8-bit UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead FIFO.
// Latency: byte pushed on the stop-sample edge, visible on o_RX_Byte/o_RX_Valid the next cycle.
// Backpressure: i_RX_Ready stalls the FIFO; a good byte arriving while full is dropped with o_Overflow.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          i_Rst_L,
  input  logic                          RX,
  output logic [DATA_W-1:0]             o_RX_Byte,
  output logic                          o_RX_Valid,
  input  logic                          i_RX_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_Framing_Err,
  output logic                          o_Overflow,
  output logic                          o_Parity_Err
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic              rx_meta, rx_sync;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push;
  logic              frm_err_d, frm_err_q;
  logic              ovf_q;
  logic              frame_ok;
  logic              fifo_full, fifo_empty, pop;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic par_err_q, par_err_d;
  assign frame_ok     = ~par_bad_q;
  assign o_Parity_Err = par_err_q;
`else
  assign frame_ok     = 1'b1;
  assign o_Parity_Err = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= LINE_IDLE;
      rx_sync <= LINE_IDLE;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // Frame FSM next-state, bit timing and push/error decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frm_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_err_d = 1'b0;
`endif
    case (state_q)
      RX_WAIT_IDLE: begin
        if (rx_sync == LINE_IDLE) state_d = RX_IDLE;
      end
      RX_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (rx_sync != LINE_IDLE) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_MID) begin
          if (rx_sync == LINE_IDLE) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = RX_PARITY;
`else
          if (bit_q == 3'd7) state_d = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_STOP;
          if (rx_sync != ^shift_q) begin
            par_bad_d = 1'b1;
            par_err_d = 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_sync == LINE_IDLE) begin
            state_d = RX_IDLE;
            push    = frame_ok;
          end else begin
            // Only one error pulse per frame: a parity failure already reported wins.
            state_d   = RX_WAIT_IDLE;
            frm_err_d = frame_ok;
          end
        end
      end
      default: state_d = RX_WAIT_IDLE;
    endcase
  end

  // FSM state, bit timing and registered error/overflow pulses.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= RX_WAIT_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= push & fifo_full & ~pop;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign pop           = o_RX_Valid & i_RX_Ready;
  assign o_RX_Valid    = ~fifo_empty;
  assign o_Framing_Err = frm_err_q;
  assign o_Overflow    = ovf_q;

  uart_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk (CLK),
    .arst_n   (i_Rst_L),
    .wr_vld   (push),
    .wr_dat   (shift_q),
    .rd_rdy   (i_RX_Ready),
    .rd_dat   (o_RX_Byte),
    .count    (o_FIFO_Count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Testbench for uart_rx_buffered: serial frame driver, output monitor and queue-based reference model.
// Latency: n/a.
// Backpressure: i_RX_Ready held, pulsed or randomized per scenario.
module tb_uart_rx_buffered;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Edges from the start-bit drive edge to the stop-sample edge:
  // 3 to enter START, CPB/2+1 to the start sample, one CPB per data/parity/stop bit.
  localparam int STOP_EDGE = 3 + CPB/2 + 1 + (9 + PAR_BITS) * CPB;

  logic                     CLK = 1'b0;
  logic                     i_Rst_L;
  logic                     RX;
  logic                     i_RX_Ready;
  logic [7:0]               o_RX_Byte;
  logic                     o_RX_Valid;
  logic [$clog2(DEPTH):0]   o_FIFO_Count;
  logic                     o_Framing_Err, o_Overflow, o_Parity_Err;

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .i_Rst_L       (i_Rst_L),
    .RX            (RX),
    .o_RX_Byte     (o_RX_Byte),
    .o_RX_Valid    (o_RX_Valid),
    .i_RX_Ready    (i_RX_Ready),
    .o_FIFO_Count  (o_FIFO_Count),
    .o_Framing_Err (o_Framing_Err),
    .o_Overflow    (o_Overflow),
    .o_Parity_Err  (o_Parity_Err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: everything observed at the falling edge, away from the active edge.
  logic [7:0] got_q [$];
  int mon_ferr = 0, mon_ovf = 0, mon_perr = 0, mon_vld = 0;
  always @(negedge CLK) begin
    if (o_RX_Valid && i_RX_Ready) got_q.push_back(o_RX_Byte);
    if (o_Framing_Err) mon_ferr++;
    if (o_Overflow)    mon_ovf++;
    if (o_Parity_Err)  mon_perr++;
    if (o_RX_Valid)    mon_vld++;
  end

  // Reference model: FIFO contents, expected delivered stream and expected pulse counts.
  logic [7:0] mdl_fifo [$];
  logic [7:0] exp_q [$];
  int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
  int rd_idx = 0;
  int vld_base;

  task automatic model_push(input logic [7:0] b);
    if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(b);
    else exp_ovf++;
  endtask

  task automatic model_pop();
    if (mdl_fifo.size() > 0) exp_q.push_back(mdl_fifo.pop_front());
  endtask

  task automatic model_drain();
    while (mdl_fifo.size() > 0) model_pop();
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, got_q.size() - rd_idx, exp_q.size());
    foreach (exp_q[i]) begin
      if (rd_idx + i < got_q.size()) check_eq({tag, "_byte"}, {24'h0, got_q[rd_idx + i]}, {24'h0, exp_q[i]});
      else check_eq({tag, "_missing"}, 32'h100, {24'h0, exp_q[i]});
    end
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_pulses(input string tag);
    check_eq({tag, "_ferr"}, mon_ferr, exp_ferr);
    check_eq({tag, "_ovf"},  mon_ovf,  exp_ovf);
    check_eq({tag, "_perr"}, mon_perr, exp_perr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    @(posedge CLK); #1; RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge CLK); #1; RX = b[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (CPB) @(posedge CLK); #1; RX = par;
`else
    if (par) RX = b[7];
`endif
    repeat (CPB) @(posedge CLK); #1; RX = stop;
    repeat (CPB) @(posedge CLK); #1;
  endtask

  initial begin
    logic [7:0] b;
    RX = 1'b1;
    i_RX_Ready = 1'b0;
    i_Rst_L = 1'b0;
    idle(3);
    check_eq("rst_byte",  o_RX_Byte, 0);
    check_eq("rst_valid", o_RX_Valid, 0);
    check_eq("rst_count", o_FIFO_Count, 0);
    check_eq("rst_errs",  {o_Framing_Err, o_Overflow, o_Parity_Err}, 0);
    i_Rst_L = 1'b1;
    idle(4);

    // Single clean byte with the consumer always ready.
    i_RX_Ready = 1'b1;
    vld_base = mon_vld;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    model_push(8'hA5); model_pop();
    idle(4);
    compare_stream("a5");
    check_eq("a5_vld_cycles", mon_vld - vld_base, 1);
    check_pulses("a5");

    // Short low glitch on an idle line.
    RX = 1'b0; idle(2); RX = 1'b1;
    idle(3 * CPB);
    check_eq("glitch_count", o_FIFO_Count, 0);
    compare_stream("glitch");
    check_pulses("glitch");

    // Back-to-back random frames against a randomly stalling consumer.
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          b = 8'($urandom_range(0, 255));
          send_frame(b, 1'b1, ^b);
          model_push(b); model_pop();
        end
      end
      begin
        repeat (8 * STOP_EDGE) begin
          @(posedge CLK); #1; i_RX_Ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_RX_Ready = 1'b1;
    idle(4 * CPB);
    compare_stream("rand");
    check_pulses("rand");

    // Framing error, long break, then recovery.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    exp_ferr++;
    idle(20 * CPB);
    RX = 1'b1;
    idle(CPB);
    send_frame(8'h11, 1'b1, ^8'h11);
    model_push(8'h11); model_pop();
    idle(4);
    compare_stream("ferr");
    check_pulses("ferr");

    // Fill with the consumer stalled; fifth byte overflows.
    i_RX_Ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      b = 8'(k);
      send_frame(b, 1'b1, ^b);
      model_push(b);
      idle(2);
      if (k == 4) begin
        check_eq("fill_count", o_FIFO_Count, DEPTH);
        check_pulses("fill");
      end
    end
    check_eq("ovf_count", o_FIFO_Count, DEPTH);
    check_pulses("ovf");

    // Pop coinciding with the stop-sample push into a full FIFO.
    fork
      send_frame(8'h06, 1'b1, ^8'h06);
      begin
        @(posedge CLK);
        repeat (STOP_EDGE - 1) @(posedge CLK);
        #1; i_RX_Ready = 1'b1;
        check_eq("coin_pre_count", o_FIFO_Count, DEPTH);
        @(posedge CLK);
        #1; i_RX_Ready = 1'b0;
        check_eq("coin_post_count", o_FIFO_Count, DEPTH);
      end
    join
    model_pop(); model_push(8'h06);
    idle(2);
    check_pulses("coin");
    i_RX_Ready = 1'b1;
    idle(DEPTH);
    check_eq("drain_count", o_FIFO_Count, 0);
    i_RX_Ready = 1'b0;
    model_drain();
    compare_stream("drain");

    // Reset in the middle of a data bit discards the frame and the FIFO.
    send_frame(8'h5A, 1'b1, ^8'h5A);
    model_push(8'h5A);
    idle(2);
    check_eq("pre_rst_count", o_FIFO_Count, 1);
    fork
      send_frame(8'hC3, 1'b1, ^8'hC3);
      begin
        @(posedge CLK);
        repeat (30) @(posedge CLK);
        #1; i_Rst_L = 1'b0;
        idle(2);
        check_eq("mid_rst_byte",  o_RX_Byte, 0);
        check_eq("mid_rst_valid", o_RX_Valid, 0);
        check_eq("mid_rst_count", o_FIFO_Count, 0);
        check_eq("mid_rst_errs",  {o_Framing_Err, o_Overflow, o_Parity_Err}, 0);
      end
    join
    mdl_fifo.delete();
    idle(2);
    i_Rst_L = 1'b1;
    idle(4);
    i_RX_Ready = 1'b1;
    send_frame(8'h96, 1'b1, ^8'h96);
    model_push(8'h96); model_pop();
    idle(4);
    compare_stream("post_rst");
    check_pulses("post_rst");

`ifdef UART_RX_PARITY_EN
    // Wrong parity is reported and dropped; correct parity is delivered.
    send_frame(8'h07, 1'b1, 1'b0);
    exp_perr++;
    idle(4);
    send_frame(8'h07, 1'b1, 1'b1);
    model_push(8'h07); model_pop();
    idle(4);
    compare_stream("parity");
    check_pulses("parity");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
